// File: rtl/frame_buffer_dual.sv
// Ping-pong RGB frame store: capture fills the back bank, display reads the front bank.
// Optional FB_DROP_COUNT_EN adds a saturating dropCount output for discarded pixels.
module frame_buffer_dual #(
  parameter int CH_BITS = 4,
  parameter int DEPTH   = 307200,
  parameter int ADDR_W  = 19
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                frameStart,
  input  logic                pixValid,
  input  logic [15:0]         pixIn,
  output logic                frameReady,
  input  logic                swapReq,
  input  logic                rdEn,
  input  logic [ADDR_W-1:0]   rdAddr,
  output logic [CH_BITS-1:0]  outR,
  output logic [CH_BITS-1:0]  outG,
  output logic [CH_BITS-1:0]  outB,
  output logic                rdValid,
`ifdef FB_DROP_COUNT_EN
  output logic [15:0]         dropCount,
`endif
  output logic                frontBank
);

  localparam int WORD_W = 3 * CH_BITS;
  localparam int IDX_W  = $clog2(2 * DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  // Both banks share one array: bank 0 at [0, DEPTH), bank 1 at [DEPTH, 2*DEPTH).
  logic [WORD_W-1:0] mem [0:2*DEPTH-1];

  state_t             state;
  logic [ADDR_W-1:0]  wrAddr;
  logic [ADDR_W-1:0]  wrPtr;
  logic               wrEn;

  logic               vld_p0;
  logic [IDX_W-1:0]   rdIdx_p0;
  logic               oob_p0;

  logic               unusedPixBits;

  function automatic logic [WORD_W-1:0] packPix(input logic [15:0] p);
    return {p[15 -: CH_BITS], p[10 -: CH_BITS], p[4 -: CH_BITS]};
  endfunction

  function automatic logic [IDX_W-1:0] memIdx(input logic bank, input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr) + (bank ? IDX_W'(DEPTH) : IDX_W'(0));
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Low colour bits below each channel's MSBs are deliberately discarded.
  assign unusedPixBits = ^pixIn;

  // A frameStart coinciding with a pixel restarts the frame and stores that pixel at 0.
  always_comb begin
    wrEn  = 1'b0;
    wrPtr = wrAddr;
    if (state == FILL && pixValid) begin
      wrEn  = 1'b1;
      wrPtr = frameStart ? '0 : wrAddr;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[memIdx(~frontBank, wrPtr)] <= packPix(pixIn);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      wrAddr     <= '0;
      frontBank  <= 1'b0;
      frameReady <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frameStart) begin
            state  <= FILL;
            wrAddr <= '0;
          end
        end
        FILL: begin
          if (wrEn) begin
            if (wrPtr == LAST_ADDR) begin
              state      <= FULL;
              frameReady <= 1'b1;
              wrAddr     <= wrPtr;
            end else begin
              wrAddr <= wrPtr + 1'b1;
            end
          end else if (frameStart) begin
            wrAddr <= '0;
          end
        end
        FULL: begin
          if (swapReq) begin
            frontBank  <= ~frontBank;
            frameReady <= 1'b0;
            wrAddr     <= '0;
            state      <= frameStart ? FILL : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_DROP_COUNT_EN
  // FILL always leaves for FULL on its DEPTH-th write, so every non-FILL pixel is a drop.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) dropCount <= '0;
    else if (pixValid && state != FILL) dropCount <= satInc(dropCount);
  end
`endif

  // ---- read stage p0: capture request, address and the bank displayed right now
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) vld_p0 <= 1'b0;
    else         vld_p0 <= rdEn;
  end

  always_ff @(posedge clk) begin
    rdIdx_p0 <= memIdx(frontBank, rdAddr);
    oob_p0   <= ({1'b0, rdAddr} >= DEPTH_EXT);
  end

  // ---- read stage p1: RAM read into the output register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rdValid <= 1'b0;
      outR    <= '0;
      outG    <= '0;
      outB    <= '0;
    end else begin
      rdValid <= vld_p0;
      if (vld_p0) begin
        if (oob_p0) begin
          outR <= '0;
          outG <= '0;
          outB <= '0;
        end else begin
          outR <= mem[rdIdx_p0][WORD_W-1 -: CH_BITS];
          outG <= mem[rdIdx_p0][2*CH_BITS-1 -: CH_BITS];
          outB <= mem[rdIdx_p0][CH_BITS-1 -: CH_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_dual.sv
// Scoreboard bench for frame_buffer_dual with a 16-pixel frame; reads are checked by a monitor.
module tb_frame_buffer_dual;
  localparam int CH_BITS = 4;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 5;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic frameStart = 1'b0;
  logic pixValid = 1'b0;
  logic [15:0] pixIn = '0;
  logic swapReq = 1'b0;
  logic rdEn = 1'b0;
  logic [ADDR_W-1:0] rdAddr = '0;
  logic frameReady, rdValid, frontBank;
  logic [CH_BITS-1:0] outR, outG, outB;
`ifdef FB_DROP_COUNT_EN
  logic [15:0] dropCount;
`endif

  int checks = 0;
  int errors = 0;
  logic [11:0] expQ[$];

  frame_buffer_dual #(.CH_BITS(CH_BITS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetN(resetN), .frameStart(frameStart), .pixValid(pixValid),
    .pixIn(pixIn), .frameReady(frameReady), .swapReq(swapReq), .rdEn(rdEn),
    .rdAddr(rdAddr), .outR(outR), .outG(outG), .outB(outB), .rdValid(rdValid),
`ifdef FB_DROP_COUNT_EN
    .dropCount(dropCount),
`endif
    .frontBank(frontBank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issueRead(input int addr, input logic [11:0] exp);
    rdEn = 1'b1;
    rdAddr = ADDR_W'(addr);
    expQ.push_back(exp);
    tick();
  endtask

  task automatic fillFrame(input logic [15:0] pix, input string name);
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    pixValid = 1'b1;
    pixIn = pix;
    repeat (DEPTH - 1) tick();
    chk({name, "_notReadyBeforeLast"}, 32'(frameReady), 32'd0);
    tick();
    pixValid = 1'b0;
    chk({name, "_readyAfterLast"}, 32'(frameReady), 32'd1);
  endtask

  task automatic swap();
    swapReq = 1'b1;
    tick();
    swapReq = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rdValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedRead: rdValid with empty scoreboard at %0t", $time);
      end else begin
        chk("readData", 32'({outR, outG, outB}), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    chk("rst_frameReady", 32'(frameReady), 32'd0);
    chk("rst_rdValid", 32'(rdValid), 32'd0);
    chk("rst_frontBank", 32'(frontBank), 32'd0);
    chk("rst_out", 32'({outR, outG, outB}), 32'd0);
    resetN = 1'b1;
    tick();

    // Frame F81F lands in bank 1 while bank 0 is displayed.
    fillFrame(16'hF81F, "f1");
    swap();
    chk("swap1_front", 32'(frontBank), 32'd1);
    chk("swap1_ready", 32'(frameReady), 32'd0);
    for (int i = 0; i < DEPTH; i++) issueRead(i, 12'hF0F);
    issueRead(20, 12'h000);
    rdEn = 1'b0;
    tick();

    // Frame 07E0 into bank 0; swap lands alongside read 4 so read 5 sees the new bank.
    fillFrame(16'h07E0, "f2");
    for (int i = 0; i < 8; i++) begin
      swapReq = (i == 4);
      issueRead(i, (i <= 4) ? 12'hF0F : 12'h0F0);
    end
    swapReq = 1'b0;
    rdEn = 1'b0;
    chk("swap2_front", 32'(frontBank), 32'd0);
    chk("swap2_ready", 32'(frameReady), 32'd0);

    // Partial frame of FFFF, restarted by frameStart with a 5555 pixel in the same cycle.
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    pixValid = 1'b1;
    pixIn = 16'hFFFF;
    repeat (7) tick();
    frameStart = 1'b1;
    pixIn = 16'h5555;
    tick();
    frameStart = 1'b0;
    repeat (DEPTH - 2) tick();
    chk("restart_notReady", 32'(frameReady), 32'd0);
    tick();
    chk("restart_ready", 32'(frameReady), 32'd1);

    // FULL: five dropped pixels, then swap+frameStart+pixel together.
    pixIn = 16'h0000;
    repeat (5) tick();
    chk("full_stillReady", 32'(frameReady), 32'd1);
    swapReq = 1'b1;
    frameStart = 1'b1;
    tick();
    swapReq = 1'b0;
    frameStart = 1'b0;
    pixValid = 1'b0;
    chk("swap3_front", 32'(frontBank), 32'd1);
    chk("swap3_ready", 32'(frameReady), 32'd0);
`ifdef FB_DROP_COUNT_EN
    chk("dropCount_full", 32'(dropCount), 32'd6);
`endif
    for (int i = 0; i < DEPTH; i++) issueRead(i, 12'h5AA);
    rdEn = 1'b0;
    // Already in FILL at address 0: no frameStart needed.
    pixValid = 1'b1;
    pixIn = 16'h07E0;
    repeat (DEPTH - 1) tick();
    chk("f3_notReady", 32'(frameReady), 32'd0);
    tick();
    pixValid = 1'b0;
    chk("f3_ready", 32'(frameReady), 32'd1);

    swap();
    chk("swap4_front", 32'(frontBank), 32'd0);
    issueRead(3, 12'h0F0);
    issueRead(15, 12'h0F0);
    rdEn = 1'b0;
    fillFrame(16'h001F, "f4");
    swap();
    chk("swap5_front", 32'(frontBank), 32'd1);
    issueRead(0, 12'h00F);
    issueRead(15, 12'h00F);
    rdEn = 1'b0;
    repeat (3) tick();

    // Reset mid-FILL with reads in flight.
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    pixValid = 1'b1;
    pixIn = 16'hFFFF;
    issueRead(2, 12'h00F);
    issueRead(3, 12'h00F);
    rdEn = 1'b0;
    pixValid = 1'b0;
    chk("preRst_rdValid", 32'(rdValid), 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    chk("midRst_rdValid", 32'(rdValid), 32'd0);
    chk("midRst_frameReady", 32'(frameReady), 32'd0);
    chk("midRst_frontBank", 32'(frontBank), 32'd0);
    chk("midRst_out", 32'({outR, outG, outB}), 32'd0);
`ifdef FB_DROP_COUNT_EN
    chk("midRst_dropCount", 32'(dropCount), 32'd0);
`endif
    expQ.delete();
    #1;
    resetN = 1'b1;
    tick();

    // Without frameStart, pixels are dropped in IDLE.
    pixValid = 1'b1;
    repeat (20) tick();
    pixValid = 1'b0;
    chk("idle_noFrame", 32'(frameReady), 32'd0);
`ifdef FB_DROP_COUNT_EN
    chk("dropCount_idle", 32'(dropCount), 32'd20);
`endif
    fillFrame(16'hF800, "f5");
    swap();
    chk("swap6_front", 32'(frontBank), 32'd1);
    issueRead(0, 12'hF00);
    issueRead(15, 12'hF00);
    issueRead(31, 12'h000);
    rdEn = 1'b0;
    repeat (4) tick();
    chk("drain", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
